// File: rtl/cpu_eu_param_pkg.sv
// Shared encodings for the parametrised execution unit: ALU opcodes and
// multiplier sequencing states.
package cpu_eu_param_pkg;

  typedef enum logic [3:0] {
    OP_PASS_S = 4'd0,
    OP_PASS_R = 4'd1,
    OP_ADD    = 4'd2,
    OP_SUB    = 4'd3,
    OP_AND    = 4'd4,
    OP_OR     = 4'd5,
    OP_XOR    = 4'd6,
    OP_NOT_S  = 4'd7,
    OP_INC    = 4'd8,
    OP_DEC    = 4'd9,
    OP_SHL    = 4'd10,
    OP_SHR    = 4'd11,
    OP_ASR    = 4'd12,
    OP_ZERO   = 4'd13,
    OP_RSVD   = 4'd14,
    OP_MUL    = 4'd15
  } alu_op_e;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_RUN  = 1'b1
  } mul_state_e;

endpackage

// File: rtl/cpu_eu_param_seq_multiplier.sv
// Shift-add sequential multiplier: one partial product per cycle, DATA_W cycles.
// product presents the accumulator including the current step, valid while done.
module seq_multiplier
  import cpu_eu_param_pkg::*;
#(
  parameter int DATA_W = 16,
  localparam int CNT_W = $clog2(DATA_W + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic                busy,
  output logic                done,
  output logic [2*DATA_W-1:0] product
);

  mul_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2*DATA_W-1:0]   mcand_q, mcand_d;
  logic [2*DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]     mplier_q, mplier_d;

  // Sequencer and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MUL_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
    end
  end

  // Next-state and iteration logic; done flags the final iteration.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    done     = 1'b0;
    case (state_q)
      MUL_IDLE: begin
        if (start) begin
          state_d  = MUL_RUN;
          cnt_d    = CNT_W'(DATA_W);
          mcand_d  = {{DATA_W{1'b0}}, a};
          mplier_d = b;
          acc_d    = '0;
        end else begin
          state_d  = MUL_IDLE;
        end
      end
      MUL_RUN: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end else begin
          acc_d = acc_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          done    = 1'b1;
          state_d = MUL_IDLE;
        end else begin
          state_d = MUL_RUN;
        end
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  assign busy    = (state_q == MUL_RUN);
  assign product = acc_d;

endmodule

// File: rtl/cpu_eu_param.sv
// Execution unit: PC, IR, register file, single-cycle ALU, N/Z/C flags and a
// sequential multiplier that owns the register write port while it runs.
module cpu_eu_param
  import cpu_eu_param_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                REG_CNT  = 8,
  parameter int                IMM_W    = 8,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  localparam int               AW       = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adr_sel,
  input  logic              pc_sel,
  input  logic              s_sel,
  input  logic              pc_ld,
  input  logic              pc_inc,
  input  logic              reg_w_en,
  input  logic              ir_ld,
  input  logic              flag_ld,
  input  logic              mul_start,
  input  logic [AW-1:0]     W_Adr,
  input  logic [AW-1:0]     R_Adr,
  input  logic [AW-1:0]     S_Adr,
  input  logic [3:0]        Alu_Op,
  input  logic [DATA_W-1:0] D_in,
  output logic [DATA_W-1:0] adr,
  output logic [DATA_W-1:0] D_out,
  output logic [DATA_W-1:0] ir_out,
  output logic              N,
  output logic              Z,
  output logic              C,
  output logic              mul_busy,
  output logic              mul_done
);

  logic [DATA_W-1:0]   pc_q, pc_d, ir_q, ir_d;
  logic [DATA_W-1:0]   regs_q [REG_CNT];
  logic [DATA_W-1:0]   regs_d [REG_CNT];
  logic                n_q, n_d, z_q, z_d, c_q, c_d;
  logic [AW-1:0]       mul_w_adr_q, mul_w_adr_d;
  logic [DATA_W-1:0]   r_op_s, s_op_s, alu_y_s, imm_sext_s;
  logic [DATA_W:0]     sum_s;
  logic                alu_c_s, mul_go_s;
  logic [2*DATA_W-1:0] mul_prod_s;

  assign r_op_s     = regs_q[R_Adr];
  assign s_op_s     = s_sel ? D_in : regs_q[S_Adr];
  assign imm_sext_s = {{(DATA_W-IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};
  assign mul_go_s   = mul_start & ~mul_busy;

  seq_multiplier #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (r_op_s),
    .b       (s_op_s),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod_s)
  );

  // ALU result and carry; carries come from a DATA_W+1-bit sum.
  always_comb begin
    sum_s   = '0;
    alu_y_s = '0;
    alu_c_s = 1'b0;
    case (alu_op_e'(Alu_Op))
      OP_PASS_S: alu_y_s = s_op_s;
      OP_PASS_R: alu_y_s = r_op_s;
      OP_ADD: begin
        sum_s   = {1'b0, r_op_s} + {1'b0, s_op_s};
        alu_y_s = sum_s[DATA_W-1:0];
        alu_c_s = sum_s[DATA_W];
      end
      OP_SUB: begin
        sum_s   = {1'b0, r_op_s} + {1'b0, ~s_op_s} + {{DATA_W{1'b0}}, 1'b1};
        alu_y_s = sum_s[DATA_W-1:0];
        alu_c_s = sum_s[DATA_W];
      end
      OP_AND:   alu_y_s = r_op_s & s_op_s;
      OP_OR:    alu_y_s = r_op_s | s_op_s;
      OP_XOR:   alu_y_s = r_op_s ^ s_op_s;
      OP_NOT_S: alu_y_s = ~s_op_s;
      OP_INC: begin
        sum_s   = {1'b0, r_op_s} + {{DATA_W{1'b0}}, 1'b1};
        alu_y_s = sum_s[DATA_W-1:0];
        alu_c_s = sum_s[DATA_W];
      end
      OP_DEC: begin
        // R + all-ones, so C=1 means no borrow just like SUB.
        sum_s   = {1'b0, r_op_s} + {1'b0, {DATA_W{1'b1}}};
        alu_y_s = sum_s[DATA_W-1:0];
        alu_c_s = sum_s[DATA_W];
      end
      OP_SHL: begin
        alu_y_s = {r_op_s[DATA_W-2:0], 1'b0};
        alu_c_s = r_op_s[DATA_W-1];
      end
      OP_SHR: begin
        alu_y_s = {1'b0, r_op_s[DATA_W-1:1]};
        alu_c_s = r_op_s[0];
      end
      OP_ASR: begin
        alu_y_s = {r_op_s[DATA_W-1], r_op_s[DATA_W-1:1]};
        alu_c_s = r_op_s[0];
      end
      default: alu_y_s = '0;
    endcase
  end

  // Next-state for PC, IR, registers and flags; multiplier completion owns
  // the write port and flags, and host writes are locked out while busy.
  always_comb begin
    pc_d        = pc_q;
    ir_d        = ir_q;
    regs_d      = regs_q;
    n_d         = n_q;
    z_d         = z_q;
    c_d         = c_q;
    mul_w_adr_d = mul_w_adr_q;
    if (pc_ld) begin
      pc_d = pc_sel ? alu_y_s : (pc_q + imm_sext_s);
    end else if (pc_inc) begin
      pc_d = pc_q + {{(DATA_W-1){1'b0}}, 1'b1};
    end else begin
      pc_d = pc_q;
    end
    if (ir_ld) begin
      ir_d = D_in;
    end else begin
      ir_d = ir_q;
    end
    if (mul_go_s) begin
      mul_w_adr_d = W_Adr;
    end else begin
      mul_w_adr_d = mul_w_adr_q;
    end
    if (mul_done) begin
      regs_d[mul_w_adr_q] = mul_prod_s[DATA_W-1:0];
      n_d = mul_prod_s[DATA_W-1];
      z_d = (mul_prod_s[DATA_W-1:0] == '0);
      c_d = (mul_prod_s[2*DATA_W-1:DATA_W] != '0);
    end else if (!mul_busy) begin
      if (reg_w_en) begin
        regs_d[W_Adr] = alu_y_s;
      end else begin
        regs_d = regs_q;
      end
      if (flag_ld) begin
        n_d = alu_y_s[DATA_W-1];
        z_d = (alu_y_s == '0);
        c_d = alu_c_s;
      end else begin
        n_d = n_q;
        z_d = z_q;
        c_d = c_q;
      end
    end else begin
      regs_d = regs_q;
    end
  end

  // Architectural state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      n_q         <= 1'b0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      mul_w_adr_q <= '0;
      for (int i = 0; i < REG_CNT; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      n_q         <= n_d;
      z_q         <= z_d;
      c_q         <= c_d;
      mul_w_adr_q <= mul_w_adr_d;
      regs_q      <= regs_d;
    end
  end

  assign adr    = adr_sel ? r_op_s : pc_q;
  assign D_out  = alu_y_s;
  assign ir_out = ir_q;
  assign N      = n_q;
  assign Z      = z_q;
  assign C      = c_q;

endmodule

// File: tb/tb_cpu_eu_param.sv
// Directed self-checking bench for cpu_eu_param (DATA_W=16, RESET_PC=0x0100).
module tb_cpu_eu_param;
  import cpu_eu_param_pkg::*;

  logic        clk, rst, adr_sel, pc_sel, s_sel, pc_ld, pc_inc;
  logic        reg_w_en, ir_ld, flag_ld, mul_start;
  logic [2:0]  W_Adr, R_Adr, S_Adr;
  logic [3:0]  Alu_Op;
  logic [15:0] D_in, adr, D_out, ir_out;
  logic        N, Z, C, mul_busy, mul_done;

  int chk_cnt = 0;
  int pass_cnt = 0;

  cpu_eu_param #(.DATA_W(16), .REG_CNT(8), .IMM_W(8), .RESET_PC(16'h0100)) dut (
    .clk(clk), .rst(rst), .adr_sel(adr_sel), .pc_sel(pc_sel), .s_sel(s_sel),
    .pc_ld(pc_ld), .pc_inc(pc_inc), .reg_w_en(reg_w_en), .ir_ld(ir_ld),
    .flag_ld(flag_ld), .mul_start(mul_start), .W_Adr(W_Adr), .R_Adr(R_Adr),
    .S_Adr(S_Adr), .Alu_Op(Alu_Op), .D_in(D_in), .adr(adr), .D_out(D_out),
    .ir_out(ir_out), .N(N), .Z(Z), .C(C), .mul_busy(mul_busy), .mul_done(mul_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reg(input string tag, input logic [2:0] a, input logic [15:0] exp);
    adr_sel = 1'b1;
    R_Adr   = a;
    #1;
    check(tag, {16'h0000, adr}, {16'h0000, exp});
    adr_sel = 1'b0;
  endtask

  task automatic check_pc(input string tag, input logic [15:0] exp);
    adr_sel = 1'b0;
    #1;
    check(tag, {16'h0000, adr}, {16'h0000, exp});
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [15:0] v);
    Alu_Op = OP_PASS_S; s_sel = 1'b1; D_in = v; W_Adr = a; reg_w_en = 1'b1;
    tick();
    reg_w_en = 1'b0;
  endtask

  // Apply a flag-loading ALU op with R=reg[ra], S=R2 and check D_out then N/Z/C.
  task automatic flag_op(input string tag, input logic [3:0] op, input logic [2:0] ra,
                         input logic [15:0] exp_d, input logic [2:0] exp_nzc);
    Alu_Op = op; R_Adr = ra; S_Adr = 3'd2; s_sel = 1'b0; flag_ld = 1'b1;
    #1;
    check({tag, "_dout"}, {16'h0000, D_out}, {16'h0000, exp_d});
    tick();
    flag_ld = 1'b0;
    check({tag, "_nzc"}, {29'd0, N, Z, C}, {29'd0, exp_nzc});
  endtask

  // Start a multiply and watch 20 cycles for busy length and the done pulse.
  task automatic run_mul(input string tag, input logic [2:0] ra, input logic [15:0] din,
                         input logic [2:0] wa, input bit disturb);
    int busy_cnt, done_cnt, done_at;
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    Alu_Op = OP_PASS_S; R_Adr = ra; s_sel = 1'b1; D_in = din; W_Adr = wa; mul_start = 1'b1;
    tick();
    mul_start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      busy_cnt += int'(mul_busy);
      if (mul_done) begin
        done_cnt++;
        done_at = i;
      end
      R_Adr = 3'd0;
      D_in  = 16'hFFFF;
      if (disturb && i == 5) begin
        mul_start = 1'b1; reg_w_en = 1'b1; flag_ld = 1'b1;
        W_Adr = 3'd5; Alu_Op = OP_PASS_S; D_in = 16'h1234;
      end
      tick();
      mul_start = 1'b0; reg_w_en = 1'b0; flag_ld = 1'b0;
      if (disturb && i == 5) check_reg({tag, "_wr_ignored"}, 3'd5, 16'h03A8);
    end
    check({tag, "_busy_cycles"}, busy_cnt, 32'd16);
    check({tag, "_done_pulses"}, done_cnt, 32'd1);
    check({tag, "_done_cycle"}, done_at, 32'd16);
  endtask

  logic [3:0]  tv_op  [14] = '{OP_PASS_S, OP_PASS_R, OP_AND, OP_OR, OP_XOR, OP_NOT_S, OP_INC,
                               OP_DEC, OP_SHL, OP_SHR, OP_ASR, OP_ZERO, OP_RSVD, OP_MUL};
  logic [2:0]  tv_ra  [14] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1,
                               3'd2, 3'd1, 3'd2, 3'd1, 3'd1, 3'd1, 3'd1};
  logic [15:0] tv_exp [14] = '{16'h0001, 16'hFFFF, 16'h0001, 16'hFFFF, 16'hFFFE, 16'hFFFE, 16'h0000,
                               16'h0000, 16'hFFFE, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000};

  initial begin
    int dones;
    rst = 1'b1; adr_sel = 1'b0; pc_sel = 1'b0; s_sel = 1'b0; pc_ld = 1'b0; pc_inc = 1'b0;
    reg_w_en = 1'b0; ir_ld = 1'b0; flag_ld = 1'b0; mul_start = 1'b0;
    W_Adr = 3'd0; R_Adr = 3'd0; S_Adr = 3'd0; Alu_Op = 4'd0; D_in = 16'h0000;
    tick();
    rst = 1'b0;

    // Reset state
    check_pc("rst_pc", 16'h0100);
    check("rst_ir", {16'h0000, ir_out}, 32'h0);
    check("rst_nzc", {29'd0, N, Z, C}, 32'd0);
    check("rst_busy_done", {30'd0, mul_busy, mul_done}, 32'd0);
    for (int i = 0; i < 8; i++) check_reg("rst_reg", 3'(i), 16'h0000);

    // ALU results and flags
    write_reg(3'd1, 16'hFFFF);
    write_reg(3'd2, 16'h0001);
    S_Adr = 3'd2; s_sel = 1'b0;
    for (int i = 0; i < 14; i++) begin
      Alu_Op = tv_op[i]; R_Adr = tv_ra[i];
      #1;
      check("alu_table", {16'h0000, D_out}, {16'h0000, tv_exp[i]});
    end
    flag_op("add", OP_ADD, 3'd1, 16'h0000, 3'b011);
    flag_op("dec_r0", OP_DEC, 3'd0, 16'hFFFF, 3'b100);
    flag_op("shr", OP_SHR, 3'd2, 16'h0000, 3'b011);
    flag_op("sub", OP_SUB, 3'd1, 16'hFFFE, 3'b101);
    Alu_Op = OP_ZERO;
    tick();
    check("flag_hold", {29'd0, N, Z, C}, {29'd0, 3'b101});

    // PC and IR
    Alu_Op = OP_PASS_S; s_sel = 1'b1; D_in = 16'h0010; pc_sel = 1'b1; pc_ld = 1'b1;
    tick();
    pc_ld = 1'b0;
    check_pc("pc_load", 16'h0010);
    D_in = 16'h00FC; ir_ld = 1'b1;
    tick();
    ir_ld = 1'b0;
    check("ir_load", {16'h0000, ir_out}, 32'h0000_00FC);
    pc_sel = 1'b0; pc_ld = 1'b1; pc_inc = 1'b1;
    tick();
    pc_ld = 1'b0; pc_inc = 1'b0;
    check_pc("pc_branch_prio", 16'h000C);
    D_in = 16'hFFFF; pc_sel = 1'b1; pc_ld = 1'b1;
    tick();
    pc_ld = 1'b0; pc_inc = 1'b1;
    tick();
    pc_inc = 1'b0;
    check_pc("pc_wrap", 16'h0000);
    tick();
    check_pc("pc_hold", 16'h0000);

    // Multiplier
    write_reg(3'd3, 16'h0012);
    run_mul("mul1", 3'd3, 16'h0034, 3'd5, 1'b0);
    check_reg("mul1_r5", 3'd5, 16'h03A8);
    check("mul1_nzc", {29'd0, N, Z, C}, 32'd0);
    write_reg(3'd3, 16'h0100);
    run_mul("mul2", 3'd3, 16'h0100, 3'd5, 1'b1);
    check_reg("mul2_r5", 3'd5, 16'h0000);
    check("mul2_nzc", {29'd0, N, Z, C}, {29'd0, 3'b011});

    // Reset during a multiply
    Alu_Op = OP_PASS_S; R_Adr = 3'd3; s_sel = 1'b1; D_in = 16'h0003; W_Adr = 3'd6; mul_start = 1'b1;
    tick();
    mul_start = 1'b0;
    for (int i = 1; i < 5; i++) tick();
    check("abort_busy_before", {31'd0, mul_busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy_after", {31'd0, mul_busy}, 32'd0);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      dones += int'(mul_done);
      tick();
    end
    check("abort_no_done", dones, 32'd0);
    check_reg("abort_r6", 3'd6, 16'h0000);
    check_reg("abort_r3", 3'd3, 16'h0000);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
